// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle core controller: branch kinds, FSM states,
// watchdog sizing and the branch resolution helper.
package multicycle_ctrl_pkg;

  typedef enum logic [1:0] {
    BrNoJump = 2'd0,
    BrBeq    = 2'd1,
    BrBlt    = 2'd2
  } branch_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StError  = 3'd6
  } ctrl_state_t;

  // Wide enough for the largest legal MEM_TIMEOUT (65535).
  localparam int unsigned WdWidth = 16;

  function automatic logic branch_taken(branch_t br, logic zero, logic lt);
    return ((br == BrBeq) && zero) || ((br == BrBlt) && lt);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Memory handshake watchdog: counts consecutive unacknowledged wait cycles and
// flags the cycle in which the MEM_TIMEOUT-th such cycle occurs.
module mem_watchdog
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WdWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + WdWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires in the wait cycle that would make the count reach MEM_TIMEOUT.
  assign expired = count_en && (({1'b0, count_q} + 17'd1) >= 17'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the non-pipelined core (fetch/decode/exec/mem/wb).
// Define CTRL_PERF_COUNTERS_EN to add cycle and retired-instruction counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_load,
  input  logic        dec_reg_write_enable,
  input  logic        dec_reg_write_select,
  input  logic        dec_data_write_enable,
  input  branch_t     dec_branch,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        busy,
  output logic        error,
  output ctrl_state_t state
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
`endif
);

  ctrl_state_t state_q, state_d, next_instr;
  logic        wd_count_en, wd_expired;
  logic        is_ld, is_sd, is_rtype;

  assign is_ld    = dec_reg_write_enable & ~dec_reg_write_select;
  assign is_sd    = dec_data_write_enable;
  assign is_rtype = dec_reg_write_enable & dec_reg_write_select;

  assign next_instr = run ? StFetch : StIdle;

  // Any cycle that is not an unacknowledged wait resets the watchdog, which
  // also covers clearing on every FETCH/MEM entry.
  assign wd_count_en = ((state_q == StFetch) & ~imem_ack) | ((state_q == StMem) & ~dmem_ack);

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (~wd_count_en),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (wd_expired) begin
          state_d = StError;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (dec_branch != BrNoJump) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken(dec_branch, alu_zero, alu_lt);
          state_d  = next_instr;
        end else if (is_ld || is_sd) begin
          state_d = StMem;
        end else if (is_rtype) begin
          state_d = StWb;
        end else begin
          pc_write = 1'b1;
          state_d  = next_instr;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = dec_data_write_enable;
        if (dmem_ack) begin
          if (is_sd) begin
            pc_write = 1'b1;
            state_d  = next_instr;
          end else begin
            state_d = StWb;
          end
        end else if (wd_expired) begin
          state_d = StError;
        end
      end
      StWb: begin
        reg_we   = 1'b1;
        pc_write = 1'b1;
        state_d  = next_instr;
      end
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign error = (state_q == StError);
  assign state = state_q;

`ifdef CTRL_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (busy && !error) cycle_d = cycle_q + CNT_WIDTH'(1);
    if (pc_write) instret_d = instret_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of single-instruction vectors
// plus hand-written sequences for reset abort, watchdog timeout and late run drop.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, dmem_ack;
  logic        dec_reg_write_enable, dec_reg_write_select, dec_data_write_enable;
  branch_t     dec_branch;
  logic        alu_zero, alu_lt;
  logic        imem_req, ir_load, dmem_req, dmem_we, reg_we, pc_write, pc_sel, busy, error;
  ctrl_state_t state;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT(Timeout)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .run                  (run),
    .imem_req             (imem_req),
    .imem_ack             (imem_ack),
    .ir_load              (ir_load),
    .dec_reg_write_enable (dec_reg_write_enable),
    .dec_reg_write_select (dec_reg_write_select),
    .dec_data_write_enable(dec_data_write_enable),
    .dec_branch           (dec_branch),
    .alu_zero             (alu_zero),
    .alu_lt               (alu_lt),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_ack             (dmem_ack),
    .reg_we               (reg_we),
    .pc_write             (pc_write),
    .pc_sel               (pc_sel),
    .busy                 (busy),
    .error                (error),
    .state                (state)
`ifdef CTRL_PERF_COUNTERS_EN
    ,
    .cycle_count          (cycle_count),
    .instret_count        (instret_count)
`endif
  );

  typedef struct {
    logic        rwe;
    logic        rsel;
    logic        dwe;
    branch_t     br;
    logic        zero;
    logic        lt;
    int unsigned mem_delay;
    int unsigned exp_cycles;
    int unsigned exp_we_cyc;
    logic        exp_pc_sel;
    int unsigned exp_mem_cycles;
    logic        exp_dmem_we;
  } vec_t;

  localparam int NumVecs = 10;
  vec_t vecs[NumVecs];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_dec(input logic rwe, input logic rsel, input logic dwe, input branch_t br,
                         input logic zero, input logic lt);
    dec_reg_write_enable  = rwe;
    dec_reg_write_select  = rsel;
    dec_data_write_enable = dwe;
    dec_branch            = br;
    alu_zero              = zero;
    alu_lt                = lt;
  endtask

  // Runs one instruction from IDLE; cycle 1 is the first FETCH cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, we_cnt, we_cyc, mem_cyc;
    logic done, sel, dwe_ok, ir_first;
    set_dec(v.rwe, v.rsel, v.dwe, v.br, v.zero, v.lt);
    run = 1'b1;
    @(posedge clk);
    cyc = 0; we_cnt = 0; we_cyc = 0; mem_cyc = 0;
    done = 1'b0; sel = 1'b0; dwe_ok = 1'b1; ir_first = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      imem_ack = (state == StFetch);
      if (state == StMem) begin
        mem_cyc++;
        dmem_ack = (mem_cyc > int'(v.mem_delay));
      end else begin
        dmem_ack = 1'b0;
      end
      #1;
      if (cyc == 1) ir_first = ir_load;
      if (reg_we) begin
        we_cnt++;
        we_cyc = cyc;
      end
      if (dmem_req && (dmem_we !== v.exp_dmem_we)) dwe_ok = 1'b0;
      if (pc_write) begin
        done = 1'b1;
        sel  = pc_sel;
        run  = 1'b0;
      end
    end
    chk($sformatf("v%0d_completed", idx), int'(done), 1);
    chk($sformatf("v%0d_cycles", idx), cyc, int'(v.exp_cycles));
    chk($sformatf("v%0d_reg_we_count", idx), we_cnt, (v.exp_we_cyc != 0) ? 1 : 0);
    chk($sformatf("v%0d_reg_we_cycle", idx), we_cyc, int'(v.exp_we_cyc));
    chk($sformatf("v%0d_pc_sel", idx), int'(sel), int'(v.exp_pc_sel));
    chk($sformatf("v%0d_mem_cycles", idx), mem_cyc, int'(v.exp_mem_cycles));
    chk($sformatf("v%0d_dmem_we", idx), int'(dwe_ok), 1);
    chk($sformatf("v%0d_ir_load_first", idx), int'(ir_first), 1);
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk($sformatf("v%0d_back_to_idle", idx), int'(state), int'(StIdle));
  endtask

  initial begin
    ctrl_state_t exp_st[8];
    int          n_req;

    //            rwe  rsel dwe  br        zero lt  dly cyc we  sel  mem we
    vecs[0] = '{1'b1, 1'b1, 1'b0, BrNoJump, 1'b0, 1'b0, 0, 4, 4, 1'b0, 0, 1'b0};  // add
    vecs[1] = '{1'b1, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0, 3, 8, 8, 1'b0, 4, 1'b0};  // ld, late ack
    vecs[2] = '{1'b0, 1'b0, 1'b1, BrNoJump, 1'b0, 1'b0, 0, 4, 0, 1'b0, 1, 1'b1};  // sd
    vecs[3] = '{1'b0, 1'b0, 1'b1, BrNoJump, 1'b0, 1'b0, 2, 6, 0, 1'b0, 3, 1'b1};  // sd, late ack
    vecs[4] = '{1'b0, 1'b0, 1'b0, BrBeq,    1'b1, 1'b0, 0, 3, 0, 1'b1, 0, 1'b0};  // beq taken
    vecs[5] = '{1'b0, 1'b0, 1'b0, BrBeq,    1'b0, 1'b1, 0, 3, 0, 1'b0, 0, 1'b0};  // beq not
    vecs[6] = '{1'b0, 1'b0, 1'b0, BrBlt,    1'b0, 1'b1, 0, 3, 0, 1'b1, 0, 1'b0};  // blt taken
    vecs[7] = '{1'b0, 1'b0, 1'b0, BrBlt,    1'b1, 1'b0, 0, 3, 0, 1'b0, 0, 1'b0};  // blt not
    vecs[8] = '{1'b0, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0, 0, 3, 0, 1'b0, 0, 1'b0};  // nop
    vecs[9] = '{1'b1, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0, 0, 5, 5, 1'b0, 1, 1'b0};  // ld

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", int'(state), int'(StIdle));
    chk("reset_busy", int'(busy), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_imem_req", int'(imem_req), 0);
    chk("reset_dmem_req", int'(dmem_req), 0);
    chk("reset_reg_we", int'(reg_we), 0);
    chk("reset_pc_write", int'(pc_write), 0);

    for (int i = 0; i < NumVecs; i++) run_vec(vecs[i], i);

    // Reset while stalled in MEM drops the data request on the next cycle.
    set_dec(1'b1, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_ack = (state == StFetch);
      dmem_ack = 1'b0;
    end
    #1;
    chk("abort_in_mem", int'(state), int'(StMem));
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_state", int'(state), int'(StIdle));
    chk("abort_dmem_req", int'(dmem_req), 0);

    // Watchdog: fetch never acknowledged.
    run = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk);
    n_req = 0;
    for (int i = 0; i < int'(Timeout); i++) begin
      @(negedge clk);
      #1;
      if (imem_req && state == StFetch) n_req++;
    end
    chk("timeout_fetch_cycles", n_req, int'(Timeout));
    @(negedge clk);
    #1;
    chk("timeout_state", int'(state), int'(StError));
    chk("timeout_error", int'(error), 1);
    chk("timeout_busy", int'(busy), 1);
    chk("timeout_imem_req", int'(imem_req), 0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("error_sticky", int'(error), 1);
    chk("error_no_ir_load", int'(ir_load), 0);
    chk("error_no_pc_write", int'(pc_write), 0);
    chk("error_no_reg_we", int'(reg_we), 0);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    run = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("error_rst_state", int'(state), int'(StIdle));
    chk("error_rst_error", int'(error), 0);

    // ld with run dropped during MEM: instruction completes, then IDLE.
    exp_st = '{StFetch, StDecode, StExec, StMem, StMem, StWb, StIdle, StIdle};
    set_dec(1'b1, 1'b0, 1'b0, BrNoJump, 1'b0, 1'b0);
    run = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      imem_ack = (state == StFetch);
      dmem_ack = (i == 4);
      if (i == 3) run = 1'b0;
      #1;
      chk($sformatf("rundrop_state_c%0d", i + 1), int'(state), int'(exp_st[i]));
      if (i == 5) begin
        chk("rundrop_reg_we", int'(reg_we), 1);
        chk("rundrop_pc_write", int'(pc_write), 1);
      end
    end
`ifdef CTRL_PERF_COUNTERS_EN
    chk("perf_instret", int'(instret_count), 1);
    chk("perf_cycles", int'(cycle_count), 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the non-pipelined core: fetch, decode, execute, memory, writeback.
- Consumes the decoder's control outputs and the ALU flags.
- Gates register-file and data-memory writes so each fires exactly once, in the correct cycle.
- Drives PC update and the req/ack handshakes to instruction and data memory, with a watchdog on both.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for imem_ack/dmem_ack before the error state; legal range 1..65535.
- CNT_WIDTH, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = execute, sampled at instruction boundaries only
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- ir_load  out  1  latch instruction register (= imem_req & imem_ack)
- dec_reg_write_enable  in  1  from decoder
- dec_reg_write_select  in  1  from decoder; 0 with reg_write_enable = ld
- dec_data_write_enable  in  1  from decoder (sd)
- dec_branch  in  2  branch_t {NO_JUMP, BEQ, BLT}
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (sd)
- dmem_ack  in  1  data access complete
- reg_we  out  1  gated register-file write enable
- pc_write  out  1  update PC this cycle
- pc_sel  out  1  0 = PC+4, 1 = branch target
- busy  out  1  state != IDLE
- error  out  1  sticky memory-timeout flag
- state  out  3  ctrl_state_t, debug visibility

Behaviour:
- Reset: state=IDLE. All outputs 0; watchdog count=0.
- Reset mid-operation aborts immediately; outstanding requests are dropped the next cycle.
- Outputs are decoded from the current state plus the current-cycle inputs (Moore, except ir_load and the ack-qualified strobes).
- IDLE: if run=1, go to FETCH.
- FETCH:
  - imem_req=1 held until imem_ack.
  - On ack: ir_load=1, go to DECODE. Ack in the first FETCH cycle is legal, giving a minimum of 1 cycle.
- DECODE: one cycle for register-file read. Always go to EXEC.
- EXEC: branch taken = (BEQ & alu_zero) | (BLT & alu_lt).
  - dec_branch != NO_JUMP: pc_write=1, pc_sel=taken, go to FETCH/IDLE.
  - ld or sd: go to MEM.
  - R-type (reg_write_enable & reg_write_select): go to WB.
  - Otherwise (unrecognised, all enables 0): NOP. pc_write=1, pc_sel=0, go to FETCH/IDLE.
- MEM:
  - dmem_req=1 held until dmem_ack; dmem_we=dec_data_write_enable for the whole MEM stay.
  - On ack, sd: pc_write=1, go to FETCH/IDLE.
  - On ack, ld: go to WB.
- WB: reg_we=1 for exactly one cycle, pc_write=1, pc_sel=0, go to FETCH/IDLE.
- FETCH/IDLE choice: FETCH if run=1, else IDLE. Instructions are never abandoned mid-flight.
- Decoder inputs must stay stable from DECODE through WB; the instruction register is held externally.
- Latency with 1-cycle acks:
  - R-type: 4 cycles
  - ld: 5 cycles
  - sd: 4 cycles
  - branch/NOP: 3 cycles
- Watchdog:
  - Counts cycles spent in FETCH or MEM with no ack; clears on state entry.
  - When count reaches MEM_TIMEOUT: go to ERROR, error=1, all requests and enables 0.
  - ERROR exits only via rst. busy=1 in ERROR.
- Simultaneous ack and timeout in the same cycle: ack wins.
- No register or memory write ever occurs outside WB/MEM.

Optional Feature:
- Macro: CTRL_PERF_COUNTERS_EN.
- Defined: adds outputs cycle_count and instret_count, both [CNT_WIDTH-1:0].
  - Both reset to 0.
  - cycle_count increments every cycle busy=1 and state != ERROR.
  - instret_count increments on every pc_write.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package Def gets ctrl_state_t: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6.
- branch_t is reused from Def unchanged.
- One sub-module: mem_watchdog (clk, rst, clear, count_en, expired; parameter MEM_TIMEOUT), instanced once.

Test Plan:
- add, acks in 1 cycle, run=1 -> states FETCH, DECODE, EXEC, WB. reg_we=1 exactly in cycle 4; pc_write=1, pc_sel=0 in the same cycle.
- ld with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with reg_we=1. Total 8 cycles.
- sd -> dmem_we=1 throughout MEM, reg_we never 1, pc_write on the ack cycle.
- beq: alu_zero=1 gives pc_sel=1; alu_zero=0 gives pc_sel=0. blt with alu_lt=1 gives pc_sel=1. pc_write=1 in EXEC each time.
- MEM_TIMEOUT=4, imem_ack stuck 0 -> error=1 after 4 FETCH cycles, then outputs 0 and state=ERROR. rst=1 for one cycle returns to IDLE with error=0.
- run dropped during MEM of ld -> ld completes with reg_we=1, then IDLE. With CTRL_PERF_COUNTERS_EN, instret_count=1.
